non_overlap_clkd: RTL



---
 rtl/non_overlap_clkd.sv | 137 +++++++++++++
 1 files changed

// File: rtl/non_overlap_clkd.sv
// non_overlap_clkd: clocked break-before-make driver for the thermometer-coded current-mirror array.
// Define NONOVERLAP_GLITCH_FILT_EN to insert a per-bit glitch filter ahead of the channel FSMs.

module non_overlap_lane #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             thermo_q,
    input  logic [CNT_W-1:0] dead_cycles,
    output logic             on,
    output logic             on_n,
    output logic             gap_nxt
);
    typedef enum logic [1:0] {OFF, ONS, GAP} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // Reset parks the channel in a zero-length gap so both drives drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= GAP;
            cnt   <= '0;
            on    <= 1'b0;
            on_n  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            on    <= (state_nxt == ONS);
            on_n  <= (state_nxt == OFF);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            OFF: begin
                if (thermo_q) begin
                    state_nxt = GAP;
                    cnt_nxt   = dead_cycles;
                end
            end
            ONS: begin
                if (!thermo_q) begin
                    state_nxt = GAP;
                    cnt_nxt   = dead_cycles;
                end
            end
            GAP: begin
                if (cnt != '0) cnt_nxt = cnt - CNT_ONE;
                else           state_nxt = thermo_q ? ONS : OFF;
            end
            default: begin
                state_nxt = GAP;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign gap_nxt = (state_nxt == GAP);
endmodule

module non_overlap_clkd #(
    parameter int WIDTH    = 256,
    parameter int CNT_W    = 4,
    parameter int FILT_LEN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] dead_cycles,
    input  logic [WIDTH-1:0] thermo,
    output logic [WIDTH-1:0] ON,
    output logic [WIDTH-1:0] ON_N,
    output logic             busy
);
    logic [WIDTH-1:0] thermo_q;
    logic [WIDTH-1:0] gap_nxt;

    if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
        $error("FILT_LEN must be in 1..15");
    end

`ifdef NONOVERLAP_GLITCH_FILT_EN
    localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

    logic [WIDTH-1:0]      smp;
    logic [WIDTH-1:0][3:0] fcnt;

    // A bit only moves once the sample has disagreed with it FILT_LEN cycles in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp      <= '0;
            thermo_q <= '0;
            fcnt     <= '0;
        end else begin
            smp <= en ? thermo : '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (smp[i] == thermo_q[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_LAST) begin
                    thermo_q[i] <= smp[i];
                    fcnt[i]     <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) thermo_q <= '0;
        else        thermo_q <= en ? thermo : '0;
    end
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        non_overlap_lane #(.CNT_W(CNT_W)) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .thermo_q   (thermo_q[g]),
            .dead_cycles(dead_cycles),
            .on         (ON[g]),
            .on_n       (ON_N[g]),
            .gap_nxt    (gap_nxt[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= 1'b1;
        else        busy <= |gap_nxt;
    end
endmodule
